// File: rtl/mmio_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mmio_ctrl
// Purpose  : Memory-mapped I/O controller sitting between the CPU data bus
//            and the PWM/ADC peripherals. Decodes accesses in the 0x8000
//            page, holds the PWM duty register, and sequences ADC conversions
//            either on demand (TRIGGER write) or on a periodic schedule.
//            Latched samples can be read back or forwarded to the PWM duty.
//
// Ports    : clock         in   system clock
//            reset         in   synchronous, active-high reset
//            read_enable   in   CPU data read strobe
//            write_enable  in   CPU data write strobe
//            address[15:0] in   CPU data address
//            write_data    in   CPU write data (16 bits)
//            read_data     out  registered MMIO read data (16 bits)
//            mmio_hit      out  registered; read_data belongs to this block
//            adc_enable    out  one-cycle conversion start pulse to the ADC
//            sample[9:0]   in   ADC result
//            duty_cycle    out  PWM duty register (8 bits)
//
// Register map (full 16-bit decode):
//            0x8000 DUTY     R/W  [7:0] duty
//            0x8010 TRIGGER  W    any write requests a conversion
//            0x8012 STATUS   R    {13'b0, pending, busy, valid}
//            0x8014 SAMPLE   R    {6'b0, sample}; read clears valid
//            0x8016 CONTROL  R/W  bit0 AUTO, bit1 FOLLOW
//            0x8018 PERIOD   R/W  auto-trigger period in cycles (0 = off)
//
// Revision : 1.0  initial release
// ============================================================================
module mmio_ctrl #(
    parameter int CONV_CYCLES = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        read_enable,
    input  logic        write_enable,
    input  logic [15:0] address,
    input  logic [15:0] write_data,
    output logic [15:0] read_data,
    output logic        mmio_hit,
    output logic        adc_enable,
    input  logic [9:0]  sample,
    output logic [7:0]  duty_cycle
);

    // ------------------------------------------------------------------------
    // Address map
    // ------------------------------------------------------------------------
    localparam logic [15:0] c_addr_duty    = 16'h8000;
    localparam logic [15:0] c_addr_trigger = 16'h8010;
    localparam logic [15:0] c_addr_status  = 16'h8012;
    localparam logic [15:0] c_addr_sample  = 16'h8014;
    localparam logic [15:0] c_addr_control = 16'h8016;
    localparam logic [15:0] c_addr_period  = 16'h8018;

    // Conversion counter terminal value. The counter is cleared on the
    // START->CONVERT edge and the latch happens on the edge that observes
    // this value, which places the latch CONV_CYCLES+2 edges after the
    // edge that accepted the request.
    localparam logic [15:0] c_conv_last = 16'(CONV_CYCLES);

    // ------------------------------------------------------------------------
    // Sequencer state
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_START   = 2'd1,
        S_CONVERT = 2'd2,
        S_LATCH   = 2'd3
    } state_t;

    state_t      r_state;
    logic [15:0] r_conv_cnt;
    logic        r_pending;
    logic        r_valid;
    logic [9:0]  r_sample;

    // Configuration and period timer
    logic        r_auto;
    logic        r_follow;
    logic [15:0] r_period;
    logic [15:0] r_timer;

    // ------------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------------
    logic w_wr_duty;
    logic w_wr_trigger;
    logic w_wr_control;
    logic w_wr_period;
    logic w_rd_sample;

    assign w_wr_duty    = write_enable && (address == c_addr_duty);
    assign w_wr_trigger = write_enable && (address == c_addr_trigger);
    assign w_wr_control = write_enable && (address == c_addr_control);
    assign w_wr_period  = write_enable && (address == c_addr_period);
    assign w_rd_sample  = read_enable  && (address == c_addr_sample);

    // ------------------------------------------------------------------------
    // Period timer: counts 0..PERIOD-1 while AUTO is on and PERIOD is
    // non-zero, ticking on the wrap.
    // ------------------------------------------------------------------------
    logic w_timer_run;
    logic w_tick;
    logic w_req;

    assign w_timer_run = r_auto && (r_period != 16'd0);
    assign w_tick      = w_timer_run && (r_timer == (r_period - 16'd1));

    // A TRIGGER write and a timer tick on the same edge merge into one request.
    assign w_req = w_wr_trigger || w_tick;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_timer <= 16'd0;
        end else if (w_wr_control || w_wr_period) begin
            // Reprogramming restarts the schedule from a clean phase.
            r_timer <= 16'd0;
        end else if (!w_timer_run || w_tick) begin
            r_timer <= 16'd0;
        end else begin
            r_timer <= r_timer + 16'd1;
        end
    end

    // ------------------------------------------------------------------------
    // Configuration registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_auto   <= 1'b0;
            r_follow <= 1'b0;
            r_period <= 16'd0;
        end else begin
            if (w_wr_control) begin
                r_auto   <= write_data[0];
                r_follow <= write_data[1];
            end
            if (w_wr_period) begin
                r_period <= write_data;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Conversion sequencer. Also owns duty_cycle, valid and pending because
    // each of those has both a CPU-side and a sequencer-side writer.
    // ------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_conv_cnt <= 16'd0;
            r_pending  <= 1'b0;
            r_valid    <= 1'b0;
            r_sample   <= 10'd0;
            adc_enable <= 1'b0;
            duty_cycle <= 8'd0;
        end else begin
            // Reading SAMPLE clears valid; a latch on the same edge overrides
            // this below so the fresh sample is not lost.
            if (w_rd_sample) begin
                r_valid <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    adc_enable <= 1'b0;
                    if (w_req || r_pending) begin
                        r_state    <= S_START;
                        adc_enable <= 1'b1;
                        r_pending  <= 1'b0;
                    end
                end

                S_START: begin
                    adc_enable <= 1'b0;
                    r_conv_cnt <= 16'd0;
                    r_state    <= S_CONVERT;
                    if (w_req) begin
                        r_pending <= 1'b1;
                    end
                end

                S_CONVERT: begin
                    adc_enable <= 1'b0;
                    if (w_req) begin
                        r_pending <= 1'b1;
                    end
                    if (r_conv_cnt == c_conv_last) begin
                        r_state  <= S_LATCH;
                        r_sample <= sample;
                        r_valid  <= 1'b1;
                        if (r_follow) begin
                            duty_cycle <= sample[9:2];
                        end
                    end else begin
                        r_conv_cnt <= r_conv_cnt + 16'd1;
                    end
                end

                S_LATCH: begin
                    // A request arriving now re-arms pending for the next
                    // round; a queued one starts immediately.
                    r_pending <= w_req;
                    if (r_pending) begin
                        r_state    <= S_START;
                        adc_enable <= 1'b1;
                    end else begin
                        r_state    <= S_IDLE;
                        adc_enable <= 1'b0;
                    end
                end

                default: begin
                    r_state    <= S_IDLE;
                    adc_enable <= 1'b0;
                end
            endcase

            // The CPU write takes priority over a FOLLOW update on the same edge.
            if (w_wr_duty) begin
                duty_cycle <= write_data[7:0];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Read path: registered, one-cycle latency, held between reads.
    // ------------------------------------------------------------------------
    logic        w_busy;
    logic        w_rd_hit;
    logic [15:0] w_rd_value;

    assign w_busy = (r_state != S_IDLE);

    always_comb begin
        w_rd_hit   = 1'b1;
        w_rd_value = 16'd0;
        case (address)
            c_addr_duty:    w_rd_value = {8'd0, duty_cycle};
            c_addr_trigger: w_rd_value = 16'd0;
            c_addr_status:  w_rd_value = {13'd0, r_pending, w_busy, r_valid};
            c_addr_sample:  w_rd_value = {6'd0, r_sample};
            c_addr_control: w_rd_value = {14'd0, r_follow, r_auto};
            c_addr_period:  w_rd_value = r_period;
            default: begin
                w_rd_hit   = 1'b0;
                w_rd_value = 16'd0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            read_data <= 16'd0;
            mmio_hit  <= 1'b0;
        end else if (read_enable) begin
            read_data <= w_rd_value;
            mmio_hit  <= w_rd_hit;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mmio_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mmio_ctrl
// Purpose  : Directed self-checking bench for mmio_ctrl (CONV_CYCLES = 16).
//            Inputs change on the falling edge; outputs are sampled on the
//            falling edge after the rising edge that updates them.
// Revision : 1.0  initial release
// ============================================================================
module tb_mmio_ctrl;

    localparam logic [15:0] c_duty    = 16'h8000;
    localparam logic [15:0] c_trigger = 16'h8010;
    localparam logic [15:0] c_status  = 16'h8012;
    localparam logic [15:0] c_sample  = 16'h8014;
    localparam logic [15:0] c_control = 16'h8016;
    localparam logic [15:0] c_period  = 16'h8018;

    logic        clock = 1'b0;
    logic        reset;
    logic        read_enable;
    logic        write_enable;
    logic [15:0] address;
    logic [15:0] write_data;
    logic [15:0] read_data;
    logic        mmio_hit;
    logic        adc_enable;
    logic [9:0]  sample;
    logic [7:0]  duty_cycle;

    int cyc = 0;
    int pulses[$];
    int n_pass = 0;
    int n_total = 0;

    mmio_ctrl #(.CONV_CYCLES(16)) dut (
        .clock        (clock),
        .reset        (reset),
        .read_enable  (read_enable),
        .write_enable (write_enable),
        .address      (address),
        .write_data   (write_data),
        .read_data    (read_data),
        .mmio_hit     (mmio_hit),
        .adc_enable   (adc_enable),
        .sample       (sample),
        .duty_cycle   (duty_cycle)
    );

    always #5 clock = ~clock;

    // Edge counter; an adc_enable pulse during cycle E..E+1 is logged as E.
    always @(posedge clock) begin
        if (adc_enable === 1'b1) pulses.push_back(cyc);
        cyc = cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // All bus tasks are entered on a falling edge and return on the next one.
    task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
        write_enable = 1'b1;
        address      = a;
        write_data   = d;
        @(negedge clock);
        write_enable = 1'b0;
    endtask

    task automatic bus_read(input logic [15:0] a);
        read_enable = 1'b1;
        address     = a;
        @(negedge clock);
        read_enable = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [15:0] a,
                          input logic exp_hit, input logic [15:0] exp_data);
        bus_read(a);
        chk(tag, {15'd0, mmio_hit, read_data}, {15'd0, exp_hit, exp_data});
    endtask

    task automatic wait_to(input int t);
        while (cyc < t) @(negedge clock);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int e0;
        int ec;
        logic [15:0] st[21];

        reset        = 1'b1;
        read_enable  = 1'b0;
        write_enable = 1'b0;
        address      = 16'd0;
        write_data   = 16'd0;
        sample       = 10'd0;
        @(negedge clock);
        @(negedge clock);
        chk("reset_outputs", {7'd0, read_data, mmio_hit, adc_enable, duty_cycle}, 32'd0);
        reset = 1'b0;
        @(negedge clock);

        // Register reset values and decode
        rd_chk("rst_duty",    c_duty,    1'b1, 16'h0000);
        rd_chk("rst_status",  c_status,  1'b1, 16'h0000);
        rd_chk("rst_control", c_control, 1'b1, 16'h0000);
        rd_chk("rst_period",  c_period,  1'b1, 16'h0000);
        rd_chk("rd_trigger",  c_trigger, 1'b1, 16'h0000);
        rd_chk("unmapped",    16'h8020,  1'b0, 16'h0000);

        // DUTY write / readback
        bus_write(c_duty, 16'h01A5);
        chk("duty_out", {24'd0, duty_cycle}, 32'h0000_00A5);
        rd_chk("duty_rd", c_duty, 1'b1, 16'h00A5);

        // Read-only write ignored; CONTROL reserved bits read 0
        bus_write(c_status, 16'hFFFF);
        rd_chk("ro_status", c_status, 1'b1, 16'h0000);
        bus_write(c_control, 16'hFFFC);
        rd_chk("ctrl_rsvd", c_control, 1'b1, 16'h0000);

        // Single triggered conversion
        sample = 10'h2C4;
        pulses.delete();
        bus_write(c_trigger, 16'h0000);
        e0 = cyc;
        chk("trig_pulse", {31'd0, adc_enable}, 32'd1);
        for (int k = 1; k <= 20; k++) begin
            bus_read(c_status);
            st[k] = read_data;
        end
        chk("st_start",     {16'd0, st[1]},  32'h2);
        chk("st_pre_latch", {16'd0, st[18]}, 32'h2);
        chk("st_latch",     {16'd0, st[19]}, 32'h3);
        chk("st_done",      {16'd0, st[20]}, 32'h1);
        rd_chk("sample_rd", c_sample, 1'b1, 16'h02C4);
        rd_chk("st_cleared", c_status, 1'b1, 16'h0000);
        chk("one_pulse_n", pulses.size(), 32'd1);
        if (pulses.size() > 0) chk("one_pulse_t", pulses[0] - e0, 32'd0);

        // Back-to-back with pending, third request dropped
        pulses.delete();
        bus_write(c_trigger, 16'h0000);
        e0 = cyc;
        repeat (2) @(negedge clock);
        bus_write(c_trigger, 16'h0000);
        repeat (2) @(negedge clock);
        bus_write(c_trigger, 16'h0000);
        wait_to(e0 + 45);
        chk("b2b_count", pulses.size(), 32'd2);
        if (pulses.size() >= 2) chk("b2b_spacing", pulses[1] - pulses[0], 32'd19);
        rd_chk("b2b_status", c_status, 1'b1, 16'h0001);

        // Auto mode with FOLLOW
        sample = 10'h3FC;
        bus_write(c_period, 16'd40);
        rd_chk("period_rd", c_period, 1'b1, 16'd40);
        pulses.delete();
        bus_write(c_control, 16'h0003);
        ec = cyc;
        wait_to(ec + 57);
        chk("follow_pre", {24'd0, duty_cycle}, 32'hA5);
        wait_to(ec + 58);
        chk("follow_post", {24'd0, duty_cycle}, 32'hFF);
        wait_to(ec + 97);
        bus_write(c_duty, 16'h005A);
        chk("duty_wins", {24'd0, duty_cycle}, 32'h5A);
        wait_to(ec + 138);
        chk("follow_again", {24'd0, duty_cycle}, 32'hFF);
        chk("auto_count", pulses.size(), 32'd3);
        if (pulses.size() >= 3) begin
            chk("auto_first", pulses[0] - ec, 32'd40);
            chk("auto_gap1", pulses[1] - pulses[0], 32'd40);
            chk("auto_gap2", pulses[2] - pulses[1], 32'd40);
        end
        bus_write(c_control, 16'h0000);
        rd_chk("auto_sample", c_sample, 1'b1, 16'h03FC);

        // Reset during CONVERT
        sample = 10'h155;
        pulses.delete();
        bus_write(c_trigger, 16'h0000);
        e0 = cyc;
        wait_to(e0 + 8);
        reset = 1'b1;
        @(negedge clock);
        chk("midrst_outputs", {7'd0, read_data, mmio_hit, adc_enable, duty_cycle}, 32'd0);
        reset = 1'b0;
        repeat (25) @(negedge clock);
        chk("midrst_pulses", pulses.size(), 32'd1);
        rd_chk("midrst_status", c_status, 1'b1, 16'h0000);

        pulses.delete();
        bus_write(c_trigger, 16'h0000);
        e0 = cyc;
        wait_to(e0 + 20);
        rd_chk("post_rst_sample", c_sample, 1'b1, 16'h0155);
        chk("post_rst_pulses", pulses.size(), 32'd1);
        chk("post_rst_duty", {24'd0, duty_cycle}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mmio_ctrl.md
# mmio_ctrl

Memory-mapped I/O controller between the NBBPU data bus and the PWM/ADC peripherals. Decodes CPU accesses in the 0x8000 page, holds the PWM duty register, and sequences ADC conversions on demand or on a programmable periodic schedule. Latched samples can be read back by the CPU or forwarded directly to the PWM duty. Instantiated in the SoC top next to the RAM; its registered `read_data` is muxed with the RAM's by `mmio_hit`.

## Interface
- `CONV_CYCLES`, 16: ADC conversion latency in clock cycles; legal range 1..65535.
- `clock`  in  1  system clock
- `reset`  in  1  synchronous, active-high reset
- `read_enable`  in  1  CPU data read strobe
- `write_enable`  in  1  CPU data write strobe
- `address`  in  16  CPU data address
- `write_data`  in  16  CPU write data
- `read_data`  out  16  registered MMIO read data
- `mmio_hit`  out  1  registered; high when `read_data` is from this block
- `adc_enable`  out  1  one-cycle conversion start pulse to ADC
- `sample`  in  10  ADC result; stable from `CONV_CYCLES` cycles after the `adc_enable` pulse
- `duty_cycle`  out  8  PWM duty register

## Operation
- Decode uses a full 16-bit compare. Unmapped addresses are ignored: reads return `mmio_hit`=0 and `read_data`=0.
- 0x8000 DUTY (R/W): bits [7:0] are the duty. Reads return {8'b0, duty}.
- 0x8010 TRIGGER (W): any write requests a conversion.
- 0x8012 STATUS (R): {13'b0, pending, busy, valid}.
- 0x8014 SAMPLE (R): {6'b0, latched sample}. A read clears `valid`.
- 0x8016 CONTROL (R/W): bit0 AUTO (periodic trigger enable), bit1 FOLLOW (duty tracks samples). Other bits read 0.
- 0x8018 PERIOD (R/W): 16-bit auto-trigger period in cycles. A value of 0 disables AUTO.
- Sequencer FSM states: IDLE, START, CONVERT, LATCH.
  - IDLE -> START when a request exists (TRIGGER write, auto tick, or pending set).
  - START: `adc_enable`=1 for exactly one cycle; -> CONVERT with counter cleared.
  - CONVERT: counts `CONV_CYCLES` cycles; -> LATCH.
  - LATCH: captures `sample`, sets `valid`. If FOLLOW=1, duty <= sample[9:2]. Then -> START if pending (pending cleared), else -> IDLE.
- `busy` = state != IDLE.
- A request while busy sets `pending`. Pending is one-deep; further requests while it is set are dropped.
- Period timer runs only while AUTO=1 and PERIOD!=0.
  - It counts 0..PERIOD-1 and emits a tick on the wrap.
  - Writing CONTROL or PERIOD clears the timer to 0.
- Simultaneous events:
  - TRIGGER write and auto tick in the same cycle count as a single request.
  - DUTY write and FOLLOW update in the same cycle: the CPU write wins.
  - SAMPLE read and LATCH in the same cycle: `valid` stays 1, and the read returns the old sample.
- A write to a read-only address and a read of TRIGGER have no effect (the read returns 0 with `mmio_hit`=1).

## Timing
- Reset values: `read_data`=0, `mmio_hit`=0, `adc_enable`=0, `duty_cycle`=0. CONTROL=0, PERIOD=0, valid=0, pending=0, timer=0, state IDLE.
- Reset mid-conversion aborts immediately: no latch and no `adc_enable` in the following cycle.
- Reads: `read_data`/`mmio_hit` are valid on the edge after the `read_enable` cycle, matching RAM read latency. They hold until the next read.
- Register writes take effect on the edge that samples `write_enable`.
- TRIGGER written on edge E0 (IDLE): `adc_enable` is high during cycle E0..E1. The sample latches and `valid` rises on edge E0+`CONV_CYCLES`+2. Duty (FOLLOW) updates on the same edge.
- Back-to-back with pending: the next `adc_enable` pulse follows in the cycle immediately after LATCH. The conversion period is therefore `CONV_CYCLES`+3 cycles.
- Auto mode: with PERIOD=P ≥ `CONV_CYCLES`+3, `adc_enable` pulses exactly every P cycles.

## Test plan
- Reset, then read all registers -> DUTY=0, STATUS=0, CONTROL=0, PERIOD=0. Unmapped read of 0x8020 -> `mmio_hit`=0, `read_data`=0.
- Write 0x8000=0x01A5 -> `duty_cycle`=0xA5 next cycle; read back -> 0x00A5.
- `CONV_CYCLES`=16, `sample`=0x2C4, write TRIGGER:
  - one `adc_enable` pulse;
  - STATUS=0x2 during the conversion;
  - `valid` set 18 edges later;
  - SAMPLE read -> 0x02C4, then STATUS=0x0.
- Two TRIGGER writes 3 cycles apart, then a third while pending -> exactly two `adc_enable` pulses, 19 cycles apart.
- CONTROL=0x3, PERIOD=40, `sample`=0x3FC -> `adc_enable` every 40 cycles, `duty_cycle`=0xFF after the first latch. A DUTY write in the LATCH cycle wins.
- Assert reset during CONVERT -> all outputs are 0 next cycle, no latch occurs, and a later TRIGGER works normally.
